mem_block_mover: RTL
====================

Name: mem_block_mover

Overview:
- Bus initiator for the 256x8 data memory.
- Drives `mem_read`, `mem_write`, the address and the write data. Captures the memory's `memtoreg_out` read data.
- Performs block copy (src→dst) or block fill (constant→dst) of up to 255 bytes without CPU involvement.
- Sits beside the datapath. A top-level mux gives the mover the memory port while `busy` is high.

Parameters:
- ADDR_W, 8, memory address width; 256-entry space, all address arithmetic modulo 2^ADDR_W.
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill.
- src_addr  input  ADDR_W  copy source base address; ignored in fill mode.
- dst_addr  input  ADDR_W  destination base address.
- length  input  8  byte count; 0 = no-op.
- fill_value  input  DATA_W  constant written in fill mode.
- rdata_in  input  DATA_W  read data from the memory's memtoreg_out.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- address_out  output  ADDR_W  memory address.
- wdata_out  output  DATA_W  memory write data.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous and active-high.
- All outputs are registered. Reset/IDLE values: mem_read=0, mem_write=0, address_out=0, wdata_out=0, busy=0, done=0.
- Internal registers: mode_q, src_q, dst_q, len_q, fill_q, idx (8-bit), data_q.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On start=1, latch all inputs and clear idx.
  - length=0 → DONE.
  - mode=0 → READ.
  - mode=1 → WRITE.
  - start=0 → stay in IDLE.
- READ (copy only):
  - mem_read=1, address_out=src_q+idx, mem_write=0.
  - At the closing edge, data_q ← rdata_in.
  - Memory read is combinational, so data is valid within the same cycle.
  - Next state: WRITE.
- WRITE:
  - mem_write=1, address_out=dst_q+idx, mem_read=0.
  - wdata_out = data_q (copy) or fill_q (fill).
  - The memory commits at the closing edge. idx ← idx+1.
  - If idx+1 == len_q → DONE.
  - Otherwise → READ (copy) or WRITE (fill).
- DONE:
  - done=1 and busy=0 for exactly one cycle, then → IDLE.
  - start arriving in DONE is ignored.
- busy=1 in READ and WRITE only.
- mem_read and mem_write are never high in the same cycle.
- Latency, with start sampled at edge 0:
  - Copy of N bytes: READ/WRITE alternate over cycles 1..2N; done in cycle 2N+1.
  - Fill of N bytes: WRITE in cycles 1..N; done in cycle N+1.
  - length=0: done in cycle 1; no memory access.
- Address wrap: src_q+idx and dst_q+idx wrap modulo 256 (0xFF → 0x00). No error is raised.
- Overlap: copy is strictly forward, byte by byte, with each read before its write.
  - If dst is in (src, src+len), already-written bytes are re-read, giving a smear result.
  - This is the defined behaviour; the caller is responsible for avoiding it if unwanted.
- start while busy: ignored; no queuing.
- Input changes after the start edge have no effect (values are latched).
- rst mid-transfer:
  - Next cycle: all outputs at reset values, state IDLE.
  - A write cycle that is active at the rst edge completes at that edge; no write follows it.
  - done is not pulsed.

Decomposition:
- Shared package `mem_mover_pkg`:
  - state encoding localparams (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3);
  - MODE_COPY=1'b0, MODE_FILL=1'b1;
  - ADDR_W/DATA_W defaults.
- Single module; no sub-module. The FSM, index counter and address adders are small enough to keep flat.

Test Plan:
- Copy: preload mem[0x10..0x13]=11,22,33,44; start with mode=0, src=0x10, dst=0x80, len=4 → mem[0x80..0x83]=11,22,33,44; mem_read/mem_write alternate; done in cycle 9; busy high in cycles 1–8.
- Fill with wrap: mode=1, dst=0xFE, len=3, fill=0xA5 → mem[0xFE], mem[0xFF], mem[0x00]=0xA5; address_out sequence FE, FF, 00; done in cycle 4.
- Zero length: len=0, any mode → no mem_read/mem_write asserted; done=1 in cycle 1; memory unchanged.
- Start while busy: second start pulse in cycle 3 of a len=4 copy with different dst → ignored; only the first destination is written; exactly one done pulse.
- Reset mid-copy: assert rst in cycle 4 of a len=4 copy (0x10→0x80) → mem[0x80] and mem[0x81] written, mem[0x82..0x83] unchanged; all outputs 0 the cycle after rst; no done pulse.
- Overlapping copy: mem[0x20..0x22]=7,8,9; copy src=0x20, dst=0x21, len=3 → mem[0x21..0x23]=7,7,7.

Source files
------------

// File: rtl/mem_block_mover_pkg.sv
// Shared definitions for the memory block mover: state encoding, mode codes, default widths.
package mem_mover_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned LEN_W      = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t READ  = 2'd1;
    localparam state_t WRITE = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_mover_if.sv
// Memory port bundle between the block mover (master) and the 256x8 data memory (slave).
interface mem_block_mover_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address_out;
    logic [DATA_W-1:0] wdata_out;
    logic [DATA_W-1:0] rdata_in;

    modport master (
        output mem_read,
        output mem_write,
        output address_out,
        output wdata_out,
        input  rdata_in
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  address_out,
        input  wdata_out,
        output rdata_in
    );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / block fill engine that owns the data memory port while busy is high.
module mem_block_mover
    import mem_mover_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_value,
    mem_block_mover_if.master bus,
    output logic              busy,
    output logic              done
);

    state_t              state_q, state_d;
    logic                mode_q,  mode_d;
    logic [ADDR_W-1:0]   src_q,   src_d;
    logic [ADDR_W-1:0]   dst_q,   dst_d;
    logic [LEN_W-1:0]    len_q,   len_d;
    logic [DATA_W-1:0]   fill_q,  fill_d;
    logic [LEN_W-1:0]    idx_q,   idx_d;
    logic [DATA_W-1:0]   data_q,  data_d;

    logic                mem_read_q,  mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   address_q,   address_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic                busy_d;
    logic                done_d;

    logic                idx_last_c;

    assign idx_last_c = ((idx_q + LEN_W'(1)) == len_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero length skips straight to DONE, fill never reads.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = DONE;
                    end else if (mode == MODE_FILL) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:  state_d = WRITE;
            WRITE: begin
                if (idx_last_c) begin
                    state_d = DONE;
                end else if (mode_q == MODE_FILL) begin
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Working-register updates: latch the request, capture read data, advance the index.
    always_comb begin
        mode_d = mode_q;
        src_d  = src_q;
        dst_d  = dst_q;
        len_d  = len_q;
        fill_d = fill_q;
        idx_d  = idx_q;
        data_d = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = length;
                    fill_d = fill_value;
                    idx_d  = '0;
                end
            end
            READ:  data_d = bus.rdata_in;
            WRITE: idx_d  = idx_q + LEN_W'(1);
            default: ;
        endcase
    end

    // Output logic: derived from the upcoming state so every output is a flop.
    always_comb begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        address_d   = '0;
        wdata_d     = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            READ: begin
                mem_read_d = 1'b1;
                address_d  = src_d + ADDR_W'(idx_d);
                busy_d     = 1'b1;
            end
            WRITE: begin
                mem_write_d = 1'b1;
                address_d   = dst_d + ADDR_W'(idx_d);
                wdata_d     = (mode_d == MODE_FILL) ? fill_d : data_d;
                busy_d      = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_COPY;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            fill_q      <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            address_q   <= '0;
            wdata_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            fill_q      <= fill_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.address_out = address_q;
    assign bus.wdata_out   = wdata_q;

endmodule
